// File: rtl/block_stat.sv
// Block statistics engine: per-block mean or max of a luma stream.
// Each completed block row is snapshotted and streamed out one column per transfer.
module block_stat #(
  parameter int unsigned BLK_COLS = 40,
  parameter int unsigned BLK_ROWS = 20,
  parameter int unsigned BLK_W    = 32,
  parameter int unsigned BLK_H    = 36,
  parameter int unsigned SHIFT    = 10,
  parameter int unsigned GAIN     = 910
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       de,
  input  logic       vs,
  input  logic [7:0] gray,
  input  logic       mode,
  input  logic       stat_ready,
  output logic       stat_valid,
  output logic [7:0] stat_data,
  output logic [5:0] stat_col,
  output logic [5:0] stat_row,
  output logic       frame_done,
  output logic       overrun
);

  localparam int unsigned AW = 8 + $clog2(BLK_W * BLK_H);
  localparam int unsigned LW = $clog2(BLK_W);
  localparam int unsigned PW = $clog2(BLK_COLS * BLK_W + 1);
  localparam int unsigned HW = (BLK_H > 1) ? $clog2(BLK_H) : 1;
  // Pixel counter saturates here so over-long lines never wrap into valid columns.
  localparam logic [PW-1:0] PIX_END = PW'(BLK_COLS * BLK_W);
  localparam logic [15:0]   GAIN_V  = 16'(GAIN);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e          r_state, w_state_nxt;
  logic            r_vs_d, r_de_d, r_mode, r_frame_done, r_overrun;
  logic [PW-1:0]   r_pix_cnt;
  logic [HW-1:0]   r_line_in_blk;
  logic [5:0]      r_blk_row, r_col, r_row;
  logic [AW-1:0]   r_acc [BLK_COLS];
  logic [AW-1:0]   r_buf [BLK_COLS];

  logic            w_vs_rise, w_de_fall, w_pix_en, w_row_done, w_start, w_xfer, w_last;
  logic [PW-1:0]   w_col;
  logic [AW-1:0]   w_sum, w_shr;
  logic [AW+15:0]  w_prod;
  logic [7:0]      w_mean;

  assign w_vs_rise  = vs & ~r_vs_d;
  assign w_de_fall  = r_de_d & ~de;
  assign w_col      = r_pix_cnt >> LW;
  assign w_pix_en   = de & (r_pix_cnt < PIX_END) & (r_blk_row < 6'(BLK_ROWS));
  assign w_row_done = w_de_fall & (r_line_in_blk == HW'(BLK_H - 1)) & (r_blk_row < 6'(BLK_ROWS));
  assign w_start    = w_row_done & ~w_vs_rise & (r_state == StIdle);
  assign w_xfer     = (r_state == StSend) & stat_ready;
  assign w_last     = (r_col == 6'(BLK_COLS - 1));

  // Edge-detect registers, frame mode latch, pixel and line counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vs_d        <= 1'b0;
      r_de_d        <= 1'b0;
      r_mode        <= 1'b0;
      r_pix_cnt     <= '0;
      r_line_in_blk <= '0;
      r_blk_row     <= '0;
    end else begin
      r_vs_d <= vs;
      r_de_d <= de;
      if (w_vs_rise) begin
        r_mode        <= mode;
        r_pix_cnt     <= '0;
        r_line_in_blk <= '0;
        r_blk_row     <= '0;
      end else begin
        if (!de)                        r_pix_cnt <= '0;
        else if (r_pix_cnt != PIX_END)  r_pix_cnt <= r_pix_cnt + 1'b1;
        if (w_de_fall && (r_blk_row < 6'(BLK_ROWS))) begin
          if (r_line_in_blk == HW'(BLK_H - 1)) begin
            r_line_in_blk <= '0;
            r_blk_row     <= r_blk_row + 1'b1;
          end else begin
            r_line_in_blk <= r_line_in_blk + 1'b1;
          end
        end
      end
    end
  end

  // Per-column sum (mean mode) or running max (max mode); snapshot on row completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < int'(BLK_COLS); c++) begin
        r_acc[c] <= '0;
        r_buf[c] <= '0;
      end
    end else begin
      for (int c = 0; c < int'(BLK_COLS); c++) begin
        if (w_vs_rise || w_row_done) begin
          r_acc[c] <= '0;
        end else if (w_pix_en && (w_col == PW'(c))) begin
          if (!r_mode)                 r_acc[c] <= r_acc[c] + {{(AW-8){1'b0}}, gray};
          else if (r_acc[c][7:0] < gray) r_acc[c] <= {{(AW-8){1'b0}}, gray};
        end
        // A completion that arrives mid-send is dropped so the row in flight stays intact.
        if (w_start) r_buf[c] <= r_acc[c];
      end
    end
  end

  // Sender state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // Sender next-state: vs_rise aborts, otherwise finish after the last column transfers.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (w_start) w_state_nxt = StSend;
      StSend: begin
        if (w_vs_rise)            w_state_nxt = StIdle;
        else if (w_xfer && w_last) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output column/row pointers, frame pulse and sticky overrun flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col        <= '0;
      r_row        <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= w_xfer & w_last & (r_row == 6'(BLK_ROWS - 1)) & ~w_vs_rise;
      if (w_vs_rise) begin
        r_col     <= '0;
        r_row     <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (w_start) begin
          r_col <= '0;
          r_row <= r_blk_row;
        end else if (w_xfer) begin
          r_col <= w_last ? 6'd0 : r_col + 1'b1;
        end
        if (w_row_done && (r_state == StSend)) r_overrun <= 1'b1;
      end
    end
  end

  // Select the buffered column and normalise it: min(255, ((sum >> SHIFT) * GAIN) >> 10).
  always_comb begin
    w_sum = '0;
    for (int c = 0; c < int'(BLK_COLS); c++) begin
      if (r_col == 6'(c)) w_sum = r_buf[c];
    end
    w_shr  = w_sum >> SHIFT;
    w_prod = {16'd0, w_shr} * {{AW{1'b0}}, GAIN_V};
    w_mean = (|w_prod[AW+15:18]) ? 8'hFF : w_prod[17:10];
  end

  assign stat_valid = (r_state == StSend);
  assign stat_data  = stat_valid ? (r_mode ? w_sum[7:0] : w_mean) : 8'd0;
  assign stat_col   = r_col;
  assign stat_row   = r_row;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: doc/block_stat.md
BLOCK_STAT -- requirements
Module: block_stat

Interface
REQ-001 SHALL have parameter BLK_COLS, default 40, blocks per row.
REQ-002 SHALL have parameter BLK_ROWS, default 20, block rows per frame.
REQ-003 SHALL have parameter BLK_W, default 32, block width in pixels, power of two.
REQ-004 SHALL have parameter BLK_H, default 36, block height in lines.
REQ-005 SHALL have parameters SHIFT (default 10) and GAIN (default 910, Q10), the mean normalisation.
REQ-006 SHALL have ports: clk  in  1  pixel clock; rstn  in  1  reset; de  in  1  active video; vs  in  1  vertical sync, active high; gray  in  8  luma; mode  in  1  0=mean, 1=max.
REQ-007 SHALL have ports: stat_ready  in  1  sink ready; stat_valid  out  1  result valid; stat_data  out  8  block statistic; stat_col  out  6  block column; stat_row  out  6  block row; frame_done  out  1  frame pulse; overrun  out  1  sticky drop flag.
REQ-008 SHALL use one clock, clk; reset rstn SHALL be asynchronous and active-low.

Function
REQ-009 SHALL register vs and de once; vs_rise = vs & ~vs_d; de_fall = de_d & ~de.
REQ-010 On vs_rise: clear pixel, line, row counters and accumulators; clear overrun; abort any send (stat_valid low next cycle); latch mode for the frame.
REQ-011 SHALL count pixels while de=1, column = pix_cnt / BLK_W; pixels with column >= BLK_COLS SHALL be ignored.
REQ-012 SHALL count lines on de_fall: line_in_blk wraps BLK_H-1 -> 0 and increments blk_row; lines with blk_row >= BLK_ROWS SHALL be ignored.
REQ-013 Mean mode: per-column accumulator, width 8+clog2(BLK_W*BLK_H), no intermediate truncation.
REQ-014 Max mode: per-column 8-bit running maximum, cleared to 0.
REQ-015 Row completion = de_fall with line_in_blk == BLK_H-1 and blk_row < BLK_ROWS; in that cycle all columns SHALL be snapshotted into an output buffer and accumulators cleared.
REQ-016 Mean output = min(255, ((sum >> SHIFT) * GAIN) >> 10); max output = stored maximum unchanged.
REQ-017 Sender FSM states IDLE, SEND; IDLE->SEND on row completion; SEND->IDLE after transfer of column BLK_COLS-1 or on vs_rise.
REQ-018 stat_valid SHALL rise the cycle after row completion with stat_col=0, stat_row=completed row.
REQ-019 Transfer occurs when stat_valid & stat_ready; column then advances by 1 next cycle; with ready held high one column per cycle, BLK_COLS cycles total.
REQ-020 While stat_valid=1 and stat_ready=0, stat_data/stat_col/stat_row SHALL hold stable.
REQ-021 Row completion while in SEND: new snapshot dropped, accumulators still cleared, overrun set (sticky until vs_rise or reset), send in progress unaffected.
REQ-022 frame_done SHALL pulse one cycle, the cycle after the final transfer of row BLK_ROWS-1.
REQ-023 vs_rise and row completion in the same cycle: vs_rise wins, no send started.

Reset
REQ-024 On rstn low: stat_valid=0, stat_data=0, stat_col=0, stat_row=0, frame_done=0, overrun=0, FSM=IDLE, all counters, accumulators, buffer = 0, mode latch = 0.
REQ-025 Reset mid-send SHALL abort immediately; after release no output until the next row completion.

Verification
REQ-026 Flat gray=128, mean mode, defaults, ready=1 -> 20 rows x 40 outputs, each stat_data = ((147456>>10)*910)>>10 = 127, one frame_done.
REQ-027 gray=255 everywhere, mean mode -> sum 293760, (286*910)>>10 = 254, no saturation; with GAIN=1024 -> saturates to 255.
REQ-028 Max mode, one pixel 200 in block (col 7, row 3), rest 10 -> stat_data 200 at col 7 row 3, 10 elsewhere.
REQ-029 stat_ready toggled 1/0 each cycle -> 40 transfers per row, no data change while stalled, values match REQ-026.
REQ-030 stat_ready held 0 through next row completion -> overrun=1, row 1 not emitted, row 0 resumes on ready; vs_rise clears overrun.
REQ-031 vs_rise at column 12 of a send -> stat_valid 0 next cycle, counters cleared, frame_done not pulsed.
